dcache_wb: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache.
- Acts as the responder for the CPU's data-memory port (MEM_ADDRIN, MEM_WriteData, MEM_MemRead, MEM_MemWrite / MEM_ReadDataOUT).
- On a miss it becomes the initiator toward slow main memory, using a 128-bit line-wide request/ready handshake.
- proc_stall freezes the pipeline while a line is evicted or filled.

---
 rtl/cache_pkg.sv | 20 ++
 rtl/dcache_ctrl_fsm.sv | 101 ++++++++++
 rtl/dcache_wb.sv | 117 +++++++++++
 tb/tb_dcache_wb.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// controller state encoding, line geometry and address-field positions.
package cache_pkg;

    typedef enum logic [1:0] {
        COMPARE   = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } cache_state_t;

    localparam int WORDS_PER_LINE = 4;
    localparam int WORD_W         = 32;
    localparam int LINE_W         = WORDS_PER_LINE * WORD_W;  // 128
    localparam int ADDR_W         = 32;
    localparam int LADDR_W        = 28;                       // line address = addr[31:4]
    localparam int OFS_LSB        = 2;                        // word offset = addr[3:2]
    localparam int OFS_W          = 2;
    localparam int IDX_LSB        = 4;                        // index starts at addr[4]

endpackage

// File: rtl/dcache_ctrl_fsm.sv
// Cache controller: COMPARE/WRITEBACK/ALLOCATE sequencing, memory handshake
// strobes, CPU stall generation and the memory-latency watchdog.
module dcache_ctrl_fsm
    import cache_pkg::*;
#(
    parameter int MEM_LAT_MAX = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_req,
    input  logic         i_hit,
    input  logic         i_victim_dirty,
    input  logic         i_mem_ready,
    output cache_state_t o_state,
    output logic         o_mem_read,
    output logic         o_mem_write,
    output logic         o_proc_stall,
    output logic         o_err_timeout,
    output logic         o_fill,
    output logic         o_wb_done
);

    // Counter only needs to reach MEM_LAT_MAX-1; it saturates there.
    localparam int              WD_W    = (MEM_LAT_MAX > 1) ? $clog2(MEM_LAT_MAX) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (MEM_LAT_MAX > 0) ? WD_W'(MEM_LAT_MAX - 1) : '0;
    localparam bit              WD_EN   = (MEM_LAT_MAX > 0);

    cache_state_t    r_state;
    logic            r_mem_read;
    logic            r_mem_write;
    logic [WD_W-1:0] r_wd_cnt;
    logic            r_err;
    logic            w_wd_expired;

    assign w_wd_expired = WD_EN && (r_wd_cnt == WD_LAST);

    // State register, registered handshake strobes and watchdog in one block.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= COMPARE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_wd_cnt    <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                COMPARE: begin
                    if (i_req && !i_hit) begin
                        r_wd_cnt <= '0;
                        if (i_victim_dirty) begin
                            r_state     <= WRITEBACK;
                            r_mem_write <= 1'b1;
                        end else begin
                            r_state    <= ALLOCATE;
                            r_mem_read <= 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    if (i_mem_ready) begin
                        // Victim written; go straight on to fetch the new line.
                        r_state     <= ALLOCATE;
                        r_mem_write <= 1'b0;
                        r_mem_read  <= 1'b1;
                        r_wd_cnt    <= '0;
                    end else if (w_wd_expired) begin
                        r_err <= 1'b1;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                ALLOCATE: begin
                    if (i_mem_ready) begin
                        r_state    <= COMPARE;
                        r_mem_read <= 1'b0;
                    end else if (w_wd_expired) begin
                        r_err <= 1'b1;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state     <= COMPARE;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

    assign o_state       = r_state;
    assign o_mem_read    = r_mem_read;
    assign o_mem_write   = r_mem_write;
    assign o_err_timeout = r_err;
    // A miss must stall in the very cycle it is seen, so this is combinational.
    assign o_proc_stall  = (r_state != COMPARE) | (i_req & ~i_hit);
    // mem_ready only means something in the two waiting states.
    assign o_fill        = (r_state == ALLOCATE)  & i_mem_ready;
    assign o_wb_done     = (r_state == WRITEBACK) & i_mem_ready;

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache. Holds the
// tag/valid/dirty/data arrays and the hit and word-select datapath; the
// sequencing lives in dcache_ctrl_fsm.
module dcache_wb
    import cache_pkg::*;
#(
    parameter int LINES       = 8,
    parameter int MEM_LAT_MAX = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                proc_read,
    input  logic                proc_write,
    input  logic [ADDR_W-1:0]   proc_addr,
    input  logic [WORD_W-1:0]   proc_wdata,
    output logic [WORD_W-1:0]   proc_rdata,
    output logic                proc_stall,
    output logic                mem_read,
    output logic                mem_write,
    output logic [LADDR_W-1:0]  mem_addr,
    output logic [LINE_W-1:0]   mem_wdata,
    input  logic [LINE_W-1:0]   mem_rdata,
    input  logic                mem_ready,
    output logic                err_timeout
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = LADDR_W - IDX_W;

    logic [TAG_W-1:0]  r_tag   [LINES];
    logic [LINE_W-1:0] r_data  [LINES];
    logic [LINES-1:0]  r_valid;
    logic [LINES-1:0]  r_dirty;

    logic [OFS_W-1:0]  w_ofs;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_req;
    logic              w_hit;
    logic              w_victim_dirty;
    logic              w_wr_hit;
    logic              w_fill;
    logic              w_wb_done;
    logic              w_addr_unused;
    cache_state_t      w_state;
    logic [LINE_W-1:0] w_line;
    logic [WORD_W-1:0] w_words [WORDS_PER_LINE];

    assign w_ofs         = proc_addr[IDX_LSB-1:OFS_LSB];
    assign w_idx         = proc_addr[IDX_LSB +: IDX_W];
    assign w_tag         = proc_addr[ADDR_W-1 -: TAG_W];
    assign w_addr_unused = ^proc_addr[OFS_LSB-1:0];

    assign w_req          = proc_read | proc_write;
    assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_victim_dirty = r_valid[w_idx] & r_dirty[w_idx];
    // A simultaneous read+write is handled as a write.
    assign w_wr_hit       = (w_state == COMPARE) & proc_write & w_hit;

    dcache_ctrl_fsm #(
        .MEM_LAT_MAX (MEM_LAT_MAX)
    ) u_ctrl (
        .clk            (clk),
        .rst            (rst),
        .i_req          (w_req),
        .i_hit          (w_hit),
        .i_victim_dirty (w_victim_dirty),
        .i_mem_ready    (mem_ready),
        .o_state        (w_state),
        .o_mem_read     (mem_read),
        .o_mem_write    (mem_write),
        .o_proc_stall   (proc_stall),
        .o_err_timeout  (err_timeout),
        .o_fill         (w_fill),
        .o_wb_done      (w_wb_done)
    );

    // Line selected by the current index, split into words for the read mux.
    assign w_line = r_data[w_idx];
    for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_word
        assign w_words[gi] = w_line[gi*WORD_W +: WORD_W];
    end

    assign proc_rdata = ((w_state == COMPARE) && proc_read && w_hit) ? w_words[w_ofs] : '0;

    // Write-back address comes from the stored tag; fill address from the CPU.
    assign mem_addr  = (w_state == WRITEBACK) ? {r_tag[w_idx], w_idx} : proc_addr[ADDR_W-1:IDX_LSB];
    assign mem_wdata = w_line;

    // Data and tag storage: line fill from memory or single-word store merge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_fill) begin
                r_data[w_idx] <= mem_rdata;
                r_tag[w_idx]  <= w_tag;
            end else if (w_wr_hit) begin
                r_data[w_idx][{w_ofs, 5'd0} +: WORD_W] <= proc_wdata;
            end
        end
    end

    // Valid/dirty bookkeeping; reset invalidates every line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (w_fill) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
        end else if (w_wb_done) begin
            r_dirty[w_idx] <= 1'b0;
        end else if (w_wr_hit) begin
            r_dirty[w_idx] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dcache_wb.sv
// Self-checking bench for dcache_wb: directed scenarios plus a randomized
// run checked against a flat "what the CPU should see" memory model.
module tb_dcache_wb;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         proc_read = 1'b0, proc_write = 1'b0;
    logic [31:0]  proc_addr = '0, proc_wdata = '0;
    logic [31:0]  proc_rdata;
    logic         proc_stall, mem_read, mem_write, mem_ready, err_timeout;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dcache_wb #(.LINES(8), .MEM_LAT_MAX(16)) dut (
        .clk(clk), .rst(rst), .proc_read(proc_read), .proc_write(proc_write),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(proc_rdata),
        .proc_stall(proc_stall), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .err_timeout(err_timeout)
    );

    int n_tests = 0, n_fail = 0;

    // Main memory contents and the architectural view the CPU must observe.
    logic [127:0] backing [logic [27:0]];
    logic [31:0]  golden  [logic [29:0]];

    // Predicted cache residency (direct-mapped placement rule only).
    bit          ref_valid [8];
    bit          ref_dirty [8];
    logic [24:0] ref_tag   [8];

    // Memory responder controls and event counters.
    bit resp_en = 1'b1;
    int resp_lat = 2;
    int wait_cnt = 0;
    bit inject_late = 1'b0;
    int n_wb = 0, n_fill = 0;

    function automatic logic [127:0] backing_line(input logic [27:0] la);
        logic [127:0] l;
        if (backing.exists(la)) return backing[la];
        for (int w = 0; w < 4; w++) l[w*32 +: 32] = {la, w[1:0], 2'b00} * 32'h9E37_79B1 + 32'h1357_0000;
        return l;
    endfunction

    function automatic logic [31:0] golden_word(input logic [29:0] wa);
        logic [127:0] l;
        if (golden.exists(wa)) return golden[wa];
        l = backing_line(wa[29:2]);
        return l[int'(wa[1:0])*32 +: 32];
    endfunction

    // Slow memory: answers a held request after resp_lat cycles with a 1-cycle ready.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_ready) begin
                mem_ready = 1'b0;
                wait_cnt  = 0;
            end else if (inject_late) begin
                inject_late = 1'b0;
                mem_rdata   = {4{32'hBAD0_BAD0}};
                mem_ready   = 1'b1;
            end else if (resp_en && (mem_read || mem_write)) begin
                n_tests++;
                if (mem_read && mem_write) begin
                    n_fail++;
                    $display("FAIL mem_exclusive: got read=%b write=%b, required not both", mem_read, mem_write);
                end
                wait_cnt++;
                if (wait_cnt >= resp_lat) begin
                    if (mem_write) begin
                        for (int w = 0; w < 4; w++) begin
                            n_tests++;
                            if (mem_wdata[w*32 +: 32] !== golden_word({mem_addr, w[1:0]})) begin
                                n_fail++;
                                $display("FAIL wb_data line %h word %0d: got %h required %h", mem_addr, w,
                                         mem_wdata[w*32 +: 32], golden_word({mem_addr, w[1:0]}));
                            end
                        end
                        backing[mem_addr] = mem_wdata;
                        n_wb++;
                    end else begin
                        mem_rdata = backing_line(mem_addr);
                        n_fill++;
                    end
                    mem_ready = 1'b1;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; proc_read = 1'b0; proc_write = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        golden.delete();
        for (int i = 0; i < 8; i++) begin ref_valid[i] = 0; ref_dirty[i] = 0; ref_tag[i] = '0; end
    endtask

    task automatic wait_unstall(output int cyc);
        cyc = 0;
        while (proc_stall === 1'b1 && cyc < 200) begin @(negedge clk); #1; cyc++; end
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_tests++; if (proc_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b required 0", proc_stall); end
        n_tests++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL rst_mem_read: got %b required 0", mem_read); end
        n_tests++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL rst_mem_write: got %b required 0", mem_write); end
        n_tests++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b required 0", err_timeout); end
        n_tests++; if (proc_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h required 0", proc_rdata); end
        $display("[TB] reset: stall=%b mem_read=%b mem_write=%b err=%b", proc_stall, mem_read, mem_write, err_timeout);
    endtask

    task automatic test_cold_miss();
        int cyc;
        apply_reset();
        resp_en = 1'b1; resp_lat = 2;
        backing[28'h4] = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
        proc_read = 1'b1; proc_addr = 32'h40;
        #1;
        n_tests++; if (proc_stall !== 1'b1) begin n_fail++; $display("FAIL cold_stall: got %b required 1", proc_stall); end
        @(negedge clk); #1;
        n_tests++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL cold_mem_read: got %b required 1", mem_read); end
        n_tests++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL cold_mem_write: got %b required 0", mem_write); end
        n_tests++; if (mem_addr !== 28'h4) begin n_fail++; $display("FAIL cold_mem_addr: got %h required 0000004", mem_addr); end
        wait_unstall(cyc);
        n_tests++; if (proc_stall !== 1'b0) begin n_fail++; $display("FAIL cold_unstall: stall still %b after %0d cycles", proc_stall, cyc); end
        n_tests++; if (proc_rdata !== 32'hD0D0_0000) begin n_fail++; $display("FAIL cold_rdata: got %h required d0d00000", proc_rdata); end
        $display("[TB] cold read 0x40 -> %h after %0d stall cycles", proc_rdata, cyc);
        @(negedge clk); proc_addr = 32'h4C; #1;
        n_tests++; if (proc_stall !== 1'b0) begin n_fail++; $display("FAIL hit_stall: got %b required 0", proc_stall); end
        n_tests++; if (proc_rdata !== 32'hD3D3_0003) begin n_fail++; $display("FAIL hit_rdata: got %h required d3d30003", proc_rdata); end
        n_tests++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL hit_mem_read: got %b required 0", mem_read); end
        $display("[TB] hit read 0x4c -> %h", proc_rdata);
        ref_valid[4] = 1; ref_tag[4] = '0;
    endtask

    task automatic test_dirty_evict();
        int cyc;
        @(negedge clk);
        proc_read = 1'b0; proc_write = 1'b1; proc_addr = 32'h44; proc_wdata = 32'hDEADBEEF;
        #1;
        n_tests++; if (proc_stall !== 1'b0) begin n_fail++; $display("FAIL wrhit_stall: got %b required 0", proc_stall); end
        golden[30'h11] = 32'hDEADBEEF; ref_dirty[4] = 1;
        $display("[TB] write hit 0x44 <- deadbeef stall=%b", proc_stall);
        @(negedge clk);
        proc_write = 1'b0; proc_read = 1'b1; proc_addr = 32'hC4;
        #1;
        n_tests++; if (proc_stall !== 1'b1) begin n_fail++; $display("FAIL evict_stall: got %b required 1", proc_stall); end
        @(negedge clk); #1;
        n_tests++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL evict_mem_write: got %b required 1", mem_write); end
        n_tests++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL evict_mem_read: got %b required 0", mem_read); end
        n_tests++; if (mem_addr !== 28'h4) begin n_fail++; $display("FAIL evict_addr: got %h required 0000004", mem_addr); end
        n_tests++; if (mem_wdata[63:32] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL evict_wdata: got %h required deadbeef", mem_wdata[63:32]); end
        cyc = 0;
        while (mem_write === 1'b1 && cyc < 50) begin @(negedge clk); #1; cyc++; end
        n_tests++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL evict_fill_read: got %b required 1", mem_read); end
        n_tests++; if (mem_addr !== 28'hC) begin n_fail++; $display("FAIL evict_fill_addr: got %h required 000000c", mem_addr); end
        wait_unstall(cyc);
        n_tests++; if (proc_rdata !== golden_word(30'h31)) begin n_fail++; $display("FAIL evict_rdata: got %h required %h", proc_rdata, golden_word(30'h31)); end
        $display("[TB] read 0xc4 after dirty eviction -> %h", proc_rdata);
        ref_tag[4] = 25'd1; ref_dirty[4] = 0;
    endtask

    task automatic test_write_miss();
        int cyc;
        @(negedge clk);
        proc_read = 1'b0; proc_write = 1'b1; proc_addr = 32'h100; proc_wdata = 32'h12345678;
        #1;
        n_tests++; if (proc_stall !== 1'b1) begin n_fail++; $display("FAIL wmiss_stall: got %b required 1", proc_stall); end
        wait_unstall(cyc);
        golden[30'h40] = 32'h12345678;
        @(negedge clk);
        proc_write = 1'b0; proc_read = 1'b1;
        #1;
        n_tests++; if (proc_stall !== 1'b0) begin n_fail++; $display("FAIL wmiss_rd_stall: got %b required 0", proc_stall); end
        n_tests++; if (proc_rdata !== 32'h12345678) begin n_fail++; $display("FAIL wmiss_rdata: got %h required 12345678", proc_rdata); end
        $display("[TB] write miss 0x100 <- 12345678, readback %h", proc_rdata);
        // The merged line must now be dirty: a conflicting read has to write it back.
        @(negedge clk); proc_addr = 32'h000; #1;
        @(negedge clk); #1;
        n_tests++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL wmiss_dirty: got mem_write %b required 1", mem_write); end
        n_tests++; if (mem_addr !== 28'h10) begin n_fail++; $display("FAIL wmiss_wb_addr: got %h required 0000010", mem_addr); end
        n_tests++; if (mem_wdata[31:0] !== 32'h12345678) begin n_fail++; $display("FAIL wmiss_wb_data: got %h required 12345678", mem_wdata[31:0]); end
        wait_unstall(cyc);
        $display("[TB] read 0x000 evicts line 0x10 -> %h", proc_rdata);
        ref_valid[0] = 1; ref_tag[0] = '0; ref_dirty[0] = 0;
    endtask

    task automatic test_reset_mid_alloc();
        logic [31:0] probe [3];
        probe[0] = 32'h200; probe[1] = 32'hC4; probe[2] = 32'h000;
        resp_en = 1'b0;
        @(negedge clk);
        proc_read = 1'b1; proc_write = 1'b0; proc_addr = 32'h200;
        @(negedge clk); #1;
        n_tests++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got mem_read %b required 1", mem_read); end
        @(negedge clk);
        rst = 1'b1; proc_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        golden.delete();
        for (int i = 0; i < 8; i++) begin ref_valid[i] = 0; ref_dirty[i] = 0; end
        #1;
        n_tests++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL midrst_mem_read: got %b required 0", mem_read); end
        n_tests++; if (proc_stall !== 1'b0) begin n_fail++; $display("FAIL midrst_stall: got %b required 0", proc_stall); end
        inject_late = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        proc_read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            proc_addr = probe[i];
            #1;
            n_tests++; if (proc_stall !== 1'b1) begin n_fail++; $display("FAIL midrst_invalid %h: got stall %b required 1", probe[i], proc_stall); end
        end
        proc_read = 1'b0;
        resp_en = 1'b1;
        $display("[TB] reset mid-allocate: mem_read=%b, lines invalid after late ready", mem_read);
    endtask

    task automatic test_random();
        int cyc, idx, tg, ofs, kind, wb0, f0;
        bit rd, wr, exp_hit, exp_wb;
        logic [31:0] addr, wd, exp_rd;
        apply_reset();
        resp_en = 1'b1;
        for (int t = 0; t < 80; t++) begin
            idx = $urandom_range(0, 7); tg = $urandom_range(0, 3); ofs = $urandom_range(0, 3);
            addr = {tg[24:0], idx[2:0], ofs[1:0], 2'b00};
            kind = $urandom_range(0, 3);
            rd = (kind != 2); wr = (kind >= 2);
            wd = $urandom; resp_lat = $urandom_range(1, 4);
            exp_hit = ref_valid[idx] && (ref_tag[idx] == tg[24:0]);
            exp_wb  = !exp_hit && ref_valid[idx] && ref_dirty[idx];
            wb0 = n_wb; f0 = n_fill;
            @(negedge clk);
            proc_read = rd; proc_write = wr; proc_addr = addr; proc_wdata = wd;
            #1;
            n_tests++; if (proc_stall !== !exp_hit) begin n_fail++; $display("FAIL rnd%0d_stall: got %b required %b", t, proc_stall, !exp_hit); end
            wait_unstall(cyc);
            n_tests++; if (proc_stall !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_timeout: stall %b after %0d cycles", t, proc_stall, cyc); end
            n_tests++; if ((n_wb - wb0) != int'(exp_wb)) begin n_fail++; $display("FAIL rnd%0d_wb: got %0d writebacks required %0d", t, n_wb - wb0, exp_wb); end
            n_tests++; if ((n_fill - f0) != int'(!exp_hit)) begin n_fail++; $display("FAIL rnd%0d_fill: got %0d fills required %0d", t, n_fill - f0, !exp_hit); end
            exp_rd = golden_word(addr[31:2]);
            if (!wr) begin
                n_tests++; if (proc_rdata !== exp_rd) begin n_fail++; $display("FAIL rnd%0d_rdata @%h: got %h required %h", t, addr, proc_rdata, exp_rd); end
            end
            ref_valid[idx] = 1; ref_tag[idx] = tg[24:0];
            if (!exp_hit) ref_dirty[idx] = 0;
            if (wr) begin ref_dirty[idx] = 1; golden[addr[31:2]] = wd; end
            $display("[TB] txn %0d %s addr=%h wdata=%h rdata=%h hit=%b wb=%b cycles=%0d",
                     t, wr ? "WR" : "RD", addr, wd, proc_rdata, exp_hit, exp_wb, cyc);
        end
        @(negedge clk);
        proc_read = 1'b0; proc_write = 1'b0;
    endtask

    task automatic test_watchdog();
        int cyc;
        apply_reset();
        resp_en = 1'b0;
        proc_read = 1'b1; proc_write = 1'b0; proc_addr = 32'h300;
        @(negedge clk); #1;
        n_tests++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL wd_mem_read: got %b required 1", mem_read); end
        repeat (14) @(negedge clk);
        #1;
        n_tests++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_early: got err %b after 14 cycles required 0", err_timeout); end
        repeat (2) @(negedge clk);
        #1;
        n_tests++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_fire: got err %b after 16 cycles required 1", err_timeout); end
        n_tests++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL wd_still_waiting: got mem_read %b required 1", mem_read); end
        resp_en = 1'b1; resp_lat = 1;
        wait_unstall(cyc);
        n_tests++; if (proc_rdata !== golden_word(30'hC0)) begin n_fail++; $display("FAIL wd_late_rdata: got %h required %h", proc_rdata, golden_word(30'hC0)); end
        @(negedge clk); proc_read = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_tests++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_sticky: got err %b required 1", err_timeout); end
        $display("[TB] watchdog: err_timeout=%b after late ready", err_timeout);
        apply_reset();
        #1;
        n_tests++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_clear: got err %b after rst required 0", err_timeout); end
        $display("[TB] watchdog cleared by rst: err_timeout=%b", err_timeout);
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_dirty_evict();
        test_write_miss();
        test_reset_mid_alloc();
        test_random();
        test_watchdog();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
